weight_dump_reader: RTL and testbench
=====================================

// Module: weight_dump_reader
// PURPOSE
//  Reader-side counterpart to the STDP learning engine's weight write-back path.
//  On a start pulse, walks every word of the synaptic weight RAM through its read port.
//  Streams each signed weight, with its address, out of a valid/ready master port to host/debug logic.
//  Holds lock high while busy so the learning engine's enable can be gated and no write-back races the dump.
// PARAMETERS
//  DATA_WIDTH  20  weight width (signed, two's complement), matches learning-engine NewW
//  ADDR_WIDTH  4   weight RAM address width
//  DEPTH       16  number of weights dumped, addresses 0..DEPTH-1; must be <= 2**ADDR_WIDTH
// PORTS
//  clk       in   1           rising-edge clock
//  rst       in   1           asynchronous, active-high reset
//  start     in   1           request a full dump; sampled only in IDLE
//  busy      out  1           high from the cycle after accepted start until done
//  lock      out  1           equals busy; external logic ANDs ~lock into learning-engine enable
//  done      out  1           one-cycle pulse after final beat handshake
//  ram_re    out  1           RAM read enable
//  ram_addr  out  ADDR_WIDTH  RAM read address
//  ram_data  in   DATA_WIDTH  signed RAM read data, valid exactly 1 cycle after ram_re
//  m_valid   out  1           output beat valid
//  m_ready   in   1           downstream accepts beat
//  m_data    out  DATA_WIDTH  signed weight (or checksum, see CONFIGURATION)
//  m_addr    out  ADDR_WIDTH  address of m_data weight
//  m_last    out  1           marks final beat of dump
//  m_csum    out  1           beat carries checksum; tied 0 when macro absent
// BEHAVIOUR
//  Reset (async, any state): FSM=IDLE, all outputs 0, read counter 0, skid FIFO empty, in-flight flag 0.
//  FSM:
//   IDLE  -> RUN on start.
//   RUN   -> DRAIN when the read for addr DEPTH-1 has issued.
//   DRAIN -> DONE on handshake of the m_last beat.
//   DONE  -> IDLE after 1 cycle; done=1 in this cycle only.
//  busy/lock: registered, high in RUN, DRAIN, DONE.
//  Read issue:
//   - ram_re=1 in RUN only when fifo_count + inflight < 2 (2-entry skid FIFO, credit based).
//   - ram_addr increments by 1 per issued read, 0..DEPTH-1, no wrap.
//   - Returned data and its address are pushed into the FIFO the cycle after ram_re.
//  Output handshake:
//   - m_valid = FIFO non-empty; a beat transfers when m_valid & m_ready.
//   - m_data/m_addr/m_last hold stable while m_valid & ~m_ready; m_valid never drops without handshake.
//   - Push and pop in the same cycle are legal; count is unchanged.
//  Latency/throughput: with m_ready held 1, first m_valid is 2 cycles after start; 1 beat/cycle sustained.
//   DEPTH beats complete in DEPTH+2 cycles after start.
//  Boundaries:
//   - start while busy: ignored.
//   - start held high: exactly one dump per IDLE visit.
//   - m_ready low indefinitely: reads stall at 2 buffered words, no overflow, no RAM read lost.
//   - DEPTH=1: single beat with m_last=1.
//  Reset mid-dump: abort immediately, no done pulse, partial stream discarded; next start restarts at addr 0.
// CONFIGURATION
//  WDUMP_CHECKSUM_EN defined:
//   - One extra beat after addr DEPTH-1 with m_csum=1 and m_last=1.
//   - Its m_data is the sum of all dumped weights modulo 2**DATA_WIDTH; m_addr=0.
//   - The weight beat at DEPTH-1 then has m_last=0.
//   - Checksum accumulator clears on accepted start and on reset.
//  WDUMP_CHECKSUM_EN undefined: no accumulator, m_csum tied 0, m_last on addr DEPTH-1.
// TESTING
//  1. RAM[i] = 3*i-20, start pulse, m_ready=1 -> 16 beats, m_data -20,-17..25, m_addr 0..15,
//     m_last on beat 15, done at cycle 18.
//  2. Same RAM, m_ready toggling 1,0,1,0 -> same 16 values in order, data stable while stalled,
//     ram_re never drives >2 outstanding words.
//  3. m_ready=0 for 50 cycles after start -> exactly 2 reads issued, m_valid=1 with addr 0;
//     release -> full stream intact.
//  4. start re-pulsed at beat 5 -> ignored, still 16 beats, one done pulse.
//  5. rst asserted during beat 7 -> all outputs 0 same cycle; new start yields addr 0..15 complete.
//  6. WDUMP_CHECKSUM_EN, RAM as test 1 -> 17th beat m_csum=1, m_last=1, m_data=40; beat 15 m_last=0.

Source files
------------

// File: rtl/weight_dump_reader.sv
// weight_dump_reader: walks the STDP weight RAM read port and streams every signed weight with its address
// out a valid/ready port, holding lock while busy. Optional checksum trailer beat: define WDUMP_CHECKSUM_EN.
module weight_dump_reader #(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_lock,
  output logic                  o_done,
  output logic                  o_ram_re,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  input  logic [DATA_WIDTH-1:0] i_ram_data,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic [ADDR_WIDTH-1:0] o_m_addr,
  output logic                  o_m_last,
  output logic                  o_m_csum
);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic                  last;
    logic                  csum;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [ADDR_WIDTH-1:0] r_if_addr;
  logic                  r_inflight;
  beat_t                 r_q [2];
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_count;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_issue;
  logic                  w_push_csum;
  logic [2:0]            w_occ;
  beat_t                 w_beat;
  beat_t                 w_head;

  assign w_head    = r_q[r_rptr];
  assign o_m_valid = (r_count != 2'd0);
  assign w_pop     = o_m_valid & i_m_ready;

  // Credit includes the beat leaving this cycle, so the 2-deep skid sustains one beat per clock.
  assign w_occ   = {1'b0, r_count} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_issue = (r_state == S_RUN) && (w_occ < 3'd2);

`ifdef WDUMP_CHECKSUM_EN
  logic                  r_csum_pend;
  logic [DATA_WIDTH-1:0] r_acc;

  assign w_push_csum = r_csum_pend && (w_occ < 3'd2);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_csum_pend <= 1'b0;
      r_acc       <= '0;
    end else begin
      if (r_state == S_IDLE && i_start)
        r_acc <= '0;
      else if (r_inflight)
        r_acc <= r_acc + i_ram_data;
      if (r_inflight && r_if_addr == LAST_ADDR)
        r_csum_pend <= 1'b1;
      else if (w_push_csum)
        r_csum_pend <= 1'b0;
    end
  end
`else
  assign w_push_csum = 1'b0;
`endif

  always_comb begin
    w_beat.data = i_ram_data;
    w_beat.addr = r_if_addr;
    w_beat.csum = 1'b0;
`ifdef WDUMP_CHECKSUM_EN
    w_beat.last = 1'b0;
    if (w_push_csum) begin
      w_beat.data = r_acc;
      w_beat.addr = '0;
      w_beat.csum = 1'b1;
      w_beat.last = 1'b1;
    end
`else
    w_beat.last = (r_if_addr == LAST_ADDR);
`endif
  end

  assign w_push = r_inflight | w_push_csum;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state   <= S_RUN;
            r_busy    <= 1'b1;
            r_rd_addr <= '0;
          end
        end
        S_RUN: begin
          if (w_issue) begin
            if (r_rd_addr == LAST_ADDR)
              r_state <= S_DRAIN;
            else
              r_rd_addr <= r_rd_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_pop && w_head.last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_inflight <= 1'b0;
      r_if_addr  <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue)
        r_if_addr <= r_rd_addr;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 2; i++)
        r_q[i] <= '0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_q[r_wptr] <= w_beat;
        r_wptr      <= ~r_wptr;
      end
      if (w_pop)
        r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign o_busy     = r_busy;
  assign o_lock     = r_busy;
  assign o_done     = r_done;
  assign o_ram_re   = w_issue;
  assign o_ram_addr = r_rd_addr;
  assign o_m_data   = w_head.data;
  assign o_m_addr   = w_head.addr;
  assign o_m_last   = w_head.last;
  assign o_m_csum   = w_head.csum;

endmodule

// File: tb/tb_weight_dump_reader.sv
// tb_weight_dump_reader: directed dumps of RAM[i]=3*i-20 under several ready patterns, restart and reset cases.
module tb_weight_dump_reader;
  localparam int DW = 20;
  localparam int AW = 4;
  localparam int D  = 16;
`ifdef WDUMP_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif
  localparam int NB = D + (CS ? 1 : 0);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          m_ready = 1'b0;
  logic [DW-1:0] ram_data = '0;
  logic          busy, lock, done, ram_re, m_valid, m_last, m_csum;
  logic [AW-1:0] ram_addr, m_addr;
  logic [DW-1:0] m_data;

  always #5 clk = ~clk;

  weight_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_busy(busy), .o_lock(lock), .o_done(done),
    .o_ram_re(ram_re), .o_ram_addr(ram_addr), .i_ram_data(ram_data),
    .o_m_valid(m_valid), .i_m_ready(m_ready),
    .o_m_data(m_data), .o_m_addr(m_addr), .o_m_last(m_last), .o_m_csum(m_csum)
  );

  logic [DW-1:0] ram [D];
  always @(posedge clk) if (ram_re) ram_data <= ram[ram_addr];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [DW+AW+1:0] q[$];
  int iss, pops, max_out, n_done;
  bit mon_en = 1'b0;
  bit prev_stall;
  logic [DW+AW-1:0] prev_beat;

  task automatic reset_mon();
    q.delete();
    iss = 0; pops = 0; max_out = 0; n_done = 0; prev_stall = 1'b0;
  endtask

  // Negedge sample reflects what the next rising edge will transfer.
  initial forever begin
    @(negedge clk);
    if (mon_en && !rst) begin
      if (prev_stall) chk("hold", 32'({m_valid, m_addr, m_data}), 32'({1'b1, prev_beat}));
      if (ram_re) iss++;
      if (m_valid && m_ready) begin
        q.push_back({m_csum, m_last, m_addr, m_data});
        pops++;
      end
      if (iss - pops > max_out) max_out = iss - pops;
      if (done) n_done++;
      prev_stall = m_valid && !m_ready;
      prev_beat  = {m_addr, m_data};
    end
  end

  task automatic do_dump(input int rmode, input bit repulse, output int done_cyc, output int first_v);
    int cyc;
    reset_mon();
    mon_en = 1'b1;
    done_cyc = -1; first_v = -1; cyc = 0;
    m_ready = (rmode == 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_lock_on", 32'({busy, lock}), 32'd3);
    while (done_cyc < 0 && cyc < 300) begin
      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 2 == 0);
        default: m_ready = (cyc >= 50);
      endcase
      start = repulse && (q.size() == 5);
      if (rmode == 2 && cyc == 50) begin
        chk("stall_reads", 32'(iss), 32'd2);
        chk("stall_head", 32'({m_valid, m_addr}), 32'({1'b1, 4'd0}));
      end
      @(posedge clk); cyc++; #1;
      if (m_valid && first_v < 0) first_v = cyc;
      if (done) done_cyc = cyc;
    end
    start = 1'b0;
    m_ready = 1'b1;
    if (done_cyc < 0) chk("done_timeout", 32'd0, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("busy_lock_off", 32'({busy, lock, done}), 32'd0);
    chk("done_pulses", 32'(n_done), 32'd1);
    chk("outstanding_le2", 32'(max_out <= 2), 32'd1);
    mon_en = 1'b0;
  endtask

  task automatic check_stream(input string t);
    logic [DW-1:0] e;
    chk({t, "_nbeats"}, 32'(q.size()), 32'(NB));
    for (int i = 0; i < D && i < q.size(); i++) begin
      e = DW'(3 * i - 20);
      chk({t, "_data"}, 32'(q[i][DW-1:0]), 32'(e));
      chk({t, "_addr_last_csum"}, 32'(q[i][DW+AW+1:DW]), 32'({1'b0, (i == D - 1) && !CS, 4'(i)}));
    end
    if (CS && q.size() == NB)
      chk({t, "_csum_beat"}, 32'(q[D]), 32'({1'b1, 1'b1, 4'd0, 20'd40}));
  endtask

  int dc, fv;

  initial begin
    for (int i = 0; i < D; i++) ram[i] = DW'(3 * i - 20);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctl", 32'({busy, lock, done, ram_re, ram_addr, m_valid, m_last, m_csum}), 32'd0);
    chk("reset_beat", 32'({m_addr, m_data}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_dump(0, 1'b0, dc, fv);
    chk("t1_first_valid", 32'(fv), 32'd2);
    chk("t1_done_cycle", 32'(dc), 32'(NB + 2));
    check_stream("t1");

    do_dump(1, 1'b0, dc, fv);
    check_stream("t2");

    do_dump(2, 1'b0, dc, fv);
    check_stream("t3");

    do_dump(0, 1'b1, dc, fv);
    check_stream("t4");

    reset_mon();
    mon_en = 1'b1;
    m_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 100 && q.size() < 7; k++) begin
      @(posedge clk); #1;
    end
    chk("t5_reached_beat7", 32'(q.size()), 32'd7);
    rst = 1'b1;
    #1;
    chk("t5_rst_ctl", 32'({busy, lock, done, ram_re, ram_addr, m_valid, m_last, m_csum}), 32'd0);
    chk("t5_rst_beat", 32'({m_addr, m_data}), 32'd0);
    mon_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t5_idle_after_rst", 32'({busy, done, m_valid}), 32'd0);
    do_dump(0, 1'b0, dc, fv);
    chk("t5_done_cycle", 32'(dc), 32'(NB + 2));
    check_stream("t5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
